// File: rtl/hw_lock_arbiter.sv
// Hardware lock table for the OmpSs manager: grants each lock id to one accelerator at a time
// and answers lock requests with an OK/REJECT ack addressed back to the requester.
module hw_lock_arbiter #(
    parameter int LOCK_ID_BITS = 8,
    parameter int ACC_ID_BITS  = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [63:0]             in_tdata,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic [ACC_ID_BITS-1:0]  in_tid,
    input  logic                    in_tlast,
    output logic [63:0]             out_tdata,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic [ACC_ID_BITS-1:0]  out_tdest,
    output logic                    out_tlast,
    input  logic                    clear_all,
    output logic [LOCK_ID_BITS:0]   locks_held,
    output logic                    err,
    input  logic                    err_clr
);

    localparam int NUM_LOCKS = 2 ** LOCK_ID_BITS;
    localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
    localparam logic [7:0] CMD_UNLOCK_CODE = 8'h06;
    localparam logic [7:0] ACK_OK_CODE     = 8'h01;
    localparam logic [7:0] ACK_REJECT_CODE = 8'h00;
    localparam logic [LOCK_ID_BITS:0] HELD_ONE = 1;

    typedef enum logic [1:0] {IDLE, ACK, DRAIN} state_t;

    state_t                  state;
    logic                    active;
    logic                    drain_after_ack;
    logic [NUM_LOCKS-1:0]    taken;
    logic [ACC_ID_BITS-1:0]  owner [NUM_LOCKS];

    logic                    accept;
    logic                    hdr_accept;
    logic [7:0]              cmd;
    logic [LOCK_ID_BITS-1:0] lock_id;
    logic                    entry_taken;
    logic                    owner_match;
    logic                    unlock_ok;
    logic                    err_set;
    logic                    unused_bits;

    assign cmd         = in_tdata[7:0];
    assign lock_id     = in_tdata[8 +: LOCK_ID_BITS];
    assign unused_bits = ^in_tdata[63:8+LOCK_ID_BITS];

    // The active flop keeps in_tready low through reset; in IDLE a clear_all pulse
    // blocks acceptance so a new grant can never race the table wipe.
    assign in_tready  = active && (((state == IDLE) && !clear_all) || (state == DRAIN));
    assign accept     = in_tvalid && in_tready;
    assign hdr_accept = accept && (state == IDLE);
    assign out_tlast  = out_tvalid;

    assign entry_taken = taken[lock_id];
    assign owner_match = (owner[lock_id] == in_tid);
    assign unlock_ok   = entry_taken && owner_match;

    assign err_set = hdr_accept &&
                     (!in_tlast ||
                      ((cmd == CMD_UNLOCK_CODE) && !unlock_ok) ||
                      ((cmd != CMD_LOCK_CODE) && (cmd != CMD_UNLOCK_CODE)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            active          <= 1'b0;
            drain_after_ack <= 1'b0;
            taken           <= '0;
            for (int i = 0; i < NUM_LOCKS; i++) begin
                owner[i] <= '0;
            end
            out_tdata       <= '0;
            out_tvalid      <= 1'b0;
            out_tdest       <= '0;
            locks_held      <= '0;
            err             <= 1'b0;
        end else begin
            active <= 1'b1;

            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hdr_accept) begin
                        if (cmd == CMD_LOCK_CODE) begin
                            if (!entry_taken) begin
                                taken[lock_id] <= 1'b1;
                                owner[lock_id] <= in_tid;
                                locks_held     <= locks_held + HELD_ONE;
                            end
                            out_tdata <= {{(56-LOCK_ID_BITS){1'b0}}, lock_id,
                                          entry_taken ? ACK_REJECT_CODE : ACK_OK_CODE};
                            out_tdest       <= in_tid;
                            out_tvalid      <= 1'b1;
                            drain_after_ack <= !in_tlast;
                            state           <= ACK;
                        end else begin
                            if ((cmd == CMD_UNLOCK_CODE) && unlock_ok) begin
                                taken[lock_id] <= 1'b0;
                                locks_held     <= locks_held - HELD_ONE;
                            end
                            if (!in_tlast) begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                ACK: begin
                    if (out_tready) begin
                        out_tvalid <= 1'b0;
                        state      <= drain_after_ack ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (accept && in_tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Overrides any table update above; a pending ack is left untouched.
            if (clear_all) begin
                taken      <= '0;
                locks_held <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hw_lock_arbiter.sv
// Self-checking bench for hw_lock_arbiter: vector table for single commands plus
// hand-written sequences for backpressure, clear_all, fill, drain and reset corners.
module tb_hw_lock_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] in_tdata = '0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [3:0]  in_tid = '0;
    logic        in_tlast = 1'b1;
    logic [63:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready = 1'b1;
    logic [3:0]  out_tdest;
    logic        out_tlast;
    logic        clear_all = 1'b0;
    logic [8:0]  locks_held;
    logic        err;
    logic        err_clr = 1'b0;

    always #5 clk = ~clk;

    hw_lock_arbiter #(.LOCK_ID_BITS(8), .ACC_ID_BITS(4)) dut (
        .clk(clk), .rstn(rstn),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .in_tid(in_tid), .in_tlast(in_tlast),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tdest(out_tdest), .out_tlast(out_tlast),
        .clear_all(clear_all), .locks_held(locks_held),
        .err(err), .err_clr(err_clr)
    );

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] id;
        logic [3:0] tid;
        logic       exp_ack;
        logic [7:0] exp_code;
        int         exp_held;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  dest;
    } ack_t;

    ack_t sb[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectAck(input logic [7:0] id, input logic [7:0] code, input logic [3:0] dest);
        ack_t a;
        a.data = {48'h0, id, code};
        a.dest = dest;
        sb.push_back(a);
    endtask

    // Drives one word and waits (bounded) for acceptance; returns on the negedge after the accepting edge.
    task automatic applyStimulus(input logic [63:0] d, input logic [3:0] t, input logic l);
        int waitc = 0;
        in_tdata  = d;
        in_tid    = t;
        in_tlast  = l;
        in_tvalid = 1'b1;
        #1;
        while (!in_tready && waitc < 40) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        checkOutput("accept_in_time", in_tready, 1'b1);
        if (in_tready) begin
            @(posedge clk);
        end
        @(negedge clk);
        in_tvalid = 1'b0;
    endtask

    task automatic pulseClear();
        clear_all = 1'b1;
        #1;
        checkOutput("ready_blocked_by_clear", in_tready, 1'b0);
        @(negedge clk);
        clear_all = 1'b0;
    endtask

    // Ack monitor: a handshake is seen just after the negedge and completes on the next posedge.
    always @(negedge clk) begin
        ack_t e;
        #2;
        if (rstn && out_tvalid && out_tready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL unexpected_ack: got data 0x%0h dest %0d, expected none", out_tdata, out_tdest);
            end else begin
                e = sb.pop_front();
                checkOutput("ack_data", out_tdata, e.data);
                checkOutput("ack_dest", out_tdest, e.dest);
                checkOutput("ack_tlast", out_tlast, 1'b1);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h04, 8'h05, 4'd2, 1'b1, 8'h01, 1, 1'b0};
        vecs[1] = '{8'h04, 8'h05, 4'd3, 1'b1, 8'h00, 1, 1'b0};
        vecs[2] = '{8'h06, 8'h05, 4'd3, 1'b0, 8'h00, 1, 1'b1};
        vecs[3] = '{8'h06, 8'h05, 4'd2, 1'b0, 8'h00, 0, 1'b0};
        vecs[4] = '{8'h04, 8'h05, 4'd3, 1'b1, 8'h01, 1, 1'b0};
        vecs[5] = '{8'h04, 8'h05, 4'd3, 1'b1, 8'h00, 1, 1'b0};
        vecs[6] = '{8'h04, 8'h07, 4'd1, 1'b1, 8'h01, 2, 1'b0};
        vecs[7] = '{8'h09, 8'h07, 4'd1, 1'b0, 8'h00, 2, 1'b1};
        vecs[8] = '{8'h06, 8'h07, 4'd1, 1'b0, 8'h00, 1, 1'b0};
        vecs[9] = '{8'h06, 8'h07, 4'd1, 1'b0, 8'h00, 1, 1'b1};

        #2;
        checkOutput("reset_in_tready", in_tready, 1'b0);
        checkOutput("reset_out_tvalid", out_tvalid, 1'b0);
        checkOutput("reset_out_tdata", out_tdata, 64'h0);
        checkOutput("reset_out_tdest", out_tdest, 4'h0);
        checkOutput("reset_locks_held", locks_held, 0);
        checkOutput("reset_err", err, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            if (vecs[i].exp_ack) begin
                expectAck(vecs[i].id, vecs[i].exp_code, vecs[i].tid);
            end
            applyStimulus({48'h0, vecs[i].id, vecs[i].cmd}, vecs[i].tid, 1'b1);
            checkOutput($sformatf("vec%0d_locks_held", i), locks_held, vecs[i].exp_held);
            checkOutput($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
        end

        // Backpressure: ack held stable for 10 cycles, then exactly one handshake.
        @(negedge clk);
        @(negedge clk);
        out_tready = 1'b0;
        checkOutput("bp_idle_tvalid", out_tvalid, 1'b0);
        expectAck(8'h10, 8'h01, 4'd4);
        applyStimulus({48'h0, 8'h10, 8'h04}, 4'd4, 1'b1);
        checkOutput("bp_latency_tvalid", out_tvalid, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_in_tready", in_tready, 1'b0);
            checkOutput("bp_out_tdata", out_tdata, 64'h1001);
            checkOutput("bp_out_tvalid", out_tvalid, 1'b1);
        end
        out_tready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("bp_single_handshake", out_tvalid, 1'b0);
        applyStimulus({48'h0, 8'h10, 8'h06}, 4'd4, 1'b1);
        checkOutput("bp_after_unlock_held", locks_held, 1);

        // clear_all while an ack is pending: table wiped, ack still delivered unchanged.
        out_tready = 1'b0;
        expectAck(8'h11, 8'h01, 4'd5);
        applyStimulus({48'h0, 8'h11, 8'h04}, 4'd5, 1'b1);
        checkOutput("clr_ack_held_before", locks_held, 2);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        #1;
        checkOutput("clr_ack_held_after", locks_held, 0);
        checkOutput("clr_ack_tvalid", out_tvalid, 1'b1);
        checkOutput("clr_ack_tdata", out_tdata, 64'h1101);
        out_tready = 1'b1;
        @(negedge clk);
        expectAck(8'h11, 8'h01, 4'd6);
        applyStimulus({48'h0, 8'h11, 8'h04}, 4'd6, 1'b1);
        checkOutput("clr_regrant_held", locks_held, 1);

        // Fill every entry, check saturation, clear, then grant the top id.
        @(negedge clk);
        @(negedge clk);
        pulseClear();
        checkOutput("fill_start_held", locks_held, 0);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] idv;
            idv = i[7:0];
            expectAck(idv, 8'h01, idv[3:0]);
            applyStimulus({48'h0, idv, 8'h04}, idv[3:0], 1'b1);
        end
        @(negedge clk);
        checkOutput("fill_held_256", locks_held, 256);
        expectAck(8'h80, 8'h00, 4'd9);
        applyStimulus({48'h0, 8'h80, 8'h04}, 4'd9, 1'b1);
        checkOutput("fill_reject_held_256", locks_held, 256);
        @(negedge clk);
        @(negedge clk);
        pulseClear();
        checkOutput("fill_cleared_held", locks_held, 0);
        expectAck(8'hFF, 8'h01, 4'd5);
        applyStimulus({48'h0, 8'hFF, 8'h04}, 4'd5, 1'b1);
        checkOutput("top_id_held", locks_held, 1);

        // Multi-word header: ack, drain extra words, sticky err, then err_clr.
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("drain_err_pre", err, 1'b0);
        expectAck(8'h20, 8'h01, 4'd6);
        applyStimulus({48'h0, 8'h20, 8'h04}, 4'd6, 1'b0);
        checkOutput("drain_err_set", err, 1'b1);
        applyStimulus({48'h0, 8'h30, 8'h04}, 4'd6, 1'b0);
        applyStimulus({48'h0, 8'h30, 8'h04}, 4'd6, 1'b1);
        checkOutput("drain_held", locks_held, 2);
        expectAck(8'h30, 8'h01, 4'd6);
        applyStimulus({48'h0, 8'h30, 8'h04}, 4'd6, 1'b1);
        checkOutput("post_drain_held", locks_held, 3);
        repeat (3) @(negedge clk);
        checkOutput("err_sticky", err, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("err_cleared", err, 1'b0);
        err_clr = 1'b1;
        applyStimulus({48'h0, 8'h40, 8'h06}, 4'd6, 1'b1);
        err_clr = 1'b0;
        checkOutput("err_set_wins", err, 1'b1);
        checkOutput("free_unlock_held", locks_held, 3);

        // Reset in the middle of an ack.
        out_tready = 1'b0;
        expectAck(8'h41, 8'h01, 4'd7);
        applyStimulus({48'h0, 8'h41, 8'h04}, 4'd7, 1'b1);
        checkOutput("rst_pre_tvalid", out_tvalid, 1'b1);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("rst_tvalid_dropped", out_tvalid, 1'b0);
        checkOutput("rst_held_zero", locks_held, 0);
        checkOutput("rst_in_tready", in_tready, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        sb.delete();
        out_tready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        expectAck(8'h41, 8'h01, 4'd8);
        applyStimulus({48'h0, 8'h41, 8'h04}, 4'd8, 1'b1);
        checkOutput("rst_regrant_held", locks_held, 1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
